// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width, 4-bit op-code constants and the
// highest legal op code. Imported by the ALU and by the arbiter that shares it.
package alu_pkg;

  localparam int XLEN = 32;

  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SUB  = 4'h1;
  localparam logic [3:0] ALU_AND  = 4'h2;
  localparam logic [3:0] ALU_OR   = 4'h3;
  localparam logic [3:0] ALU_XOR  = 4'h4;
  localparam logic [3:0] ALU_SLL  = 4'h5;
  localparam logic [3:0] ALU_SRL  = 4'h6;
  localparam logic [3:0] ALU_SRA  = 4'h7;
  localparam logic [3:0] ALU_SLTU = 4'h8;
  localparam logic [3:0] ALU_SLT  = 4'h9;
  localparam logic [3:0] ALU_LUI  = 4'hA;

  // Codes above this value are illegal.
  localparam logic [3:0] ALU_OP_MAX = ALU_LUI;

endpackage

// File: rtl/alu.sv
// Purely combinational integer ALU.
// Ports:
//   op     in  4     op code (alu_pkg::ALU_*)
//   a, b   in  XLEN  operands; shifts use b[4:0] as the amount
//   result out XLEN  ALU result (0 for illegal op codes)
//   zero   out 1     result == 0
//   err    out 1     op code above ALU_OP_MAX
module alu
  import alu_pkg::*;
(
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            err
);

  logic signed [XLEN-1:0] a_s;
  logic signed [XLEN-1:0] b_s;
  logic [4:0]             shamt;

  assign a_s   = $signed(a);
  assign b_s   = $signed(b);
  assign shamt = b[4:0];

  always_comb begin
    result = '0;
    err    = (op > ALU_OP_MAX);
    case (op)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_SLL:  result = a << shamt;
      ALU_SRL:  result = a >> shamt;
      ALU_SRA:  result = $unsigned(a_s >>> shamt);
      ALU_SLTU: result = {{(XLEN-1){1'b0}}, (a < b)};
      ALU_SLT:  result = {{(XLEN-1){1'b0}}, (a_s < b_s)};
      ALU_LUI:  result = b;
      default:  result = '0;
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters with round-robin
// arbitration and valid/ready handshakes. The ALU result is registered in a
// single output slot (one-cycle latency) together with requester id and tag.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   per-port request handshake (bit i = port i)
//   req_a/req_b           operands, port i at [XLEN*i +: XLEN]
//   req_ctrl              op codes, port i at [4*i +: 4]
//   req_tag               caller tags, port i at [TAG_W*i +: TAG_W]
//   rsp_valid/rsp_ready   response handshake
//   rsp_result/zero/err   registered ALU outputs
//   rsp_id/rsp_tag        issuing port and its tag
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [2*XLEN-1:0]    req_a,
  input  logic [2*XLEN-1:0]    req_b,
  input  logic [7:0]           req_ctrl,
  input  logic [2*TAG_W-1:0]   req_tag,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [XLEN-1:0]      rsp_result,
  output logic                 rsp_zero,
  output logic                 rsp_err,
  output logic                 rsp_id,
  output logic [TAG_W-1:0]     rsp_tag
);

  logic             prio_q, prio_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [XLEN-1:0]  rsp_result_q, rsp_result_d;
  logic             rsp_zero_q, rsp_zero_d;
  logic             rsp_err_q, rsp_err_d;
  logic             rsp_id_q, rsp_id_d;
  logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;

  logic             slot_free;
  logic [1:0]       grant;
  logic             accept;
  logic             sel;

  logic [3:0]       alu_op;
  logic [XLEN-1:0]  alu_a, alu_b, alu_result;
  logic             alu_zero, alu_err;
  logic [TAG_W-1:0] sel_tag;

  // Arbitration: prio only breaks ties, so a lone requester is always granted.
  always_comb begin
    slot_free = !rsp_valid_q | rsp_ready;
    if (&req_valid) grant = prio_q ? 2'b10 : 2'b01;
    else            grant = req_valid;
    req_ready = grant & {2{slot_free & rst_n}};
    accept    = |(req_valid & req_ready);
    sel       = req_ready[1];
  end

  // Operand mux in front of the shared ALU.
  always_comb begin
    alu_op  = sel ? req_ctrl[7:4]            : req_ctrl[3:0];
    alu_a   = sel ? req_a[XLEN +: XLEN]      : req_a[0 +: XLEN];
    alu_b   = sel ? req_b[XLEN +: XLEN]      : req_b[0 +: XLEN];
    sel_tag = sel ? req_tag[TAG_W +: TAG_W]  : req_tag[0 +: TAG_W];
  end

  alu u_alu (
    .op     (alu_op),
    .a      (alu_a),
    .b      (alu_b),
    .result (alu_result),
    .zero   (alu_zero),
    .err    (alu_err)
  );

  // Slot update: an accept reloads (even while draining), otherwise a drain empties it.
  always_comb begin
    prio_d       = prio_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_err_d    = rsp_err_q;
    rsp_id_d     = rsp_id_q;
    rsp_tag_d    = rsp_tag_q;
    if (accept) begin
      rsp_valid_d  = 1'b1;
      rsp_result_d = alu_result;
      rsp_zero_d   = alu_zero;
      rsp_err_d    = alu_err;
      rsp_id_d     = sel;
      rsp_tag_d    = sel_tag;
      prio_d       = !sel;
    end else if (rsp_ready) begin
      rsp_valid_d  = 1'b0;
    end
  end

  // Result register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q       <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_tag_q    <= '0;
    end else begin
      prio_q       <= prio_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_err_q    <= rsp_err_d;
      rsp_id_q     <= rsp_id_d;
      rsp_tag_q    <= rsp_tag_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;
  assign rsp_err    = rsp_err_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_tag    = rsp_tag_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: directed vector table, multi-cycle corner
// sequences (alternation, backpressure, async reset) and a randomized run
// checked against a transaction-level reference model.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int TW = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [63:0]       req_a, req_b;
  logic [7:0]        req_ctrl;
  logic [2*TW-1:0]   req_tag;
  logic              rsp_valid, rsp_ready;
  logic [31:0]       rsp_result;
  logic              rsp_zero, rsp_err, rsp_id;
  logic [TW-1:0]     rsp_tag;

  alu_arbiter #(.TAG_W(TW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ctrl   (req_ctrl),
    .req_tag    (req_tag),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .rsp_err    (rsp_err),
    .rsp_id     (rsp_id),
    .rsp_tag    (rsp_tag)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_port(input int p, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [3:0] tag);
    req_a[32*p +: 32]  = a;
    req_b[32*p +: 32]  = b;
    req_ctrl[4*p +: 4] = op;
    req_tag[TW*p +: TW] = tag;
  endtask

  // Reference ALU built from the op definitions with plain arithmetic.
  typedef struct packed {
    logic [31:0] res;
    logic        z;
    logic        e;
  } alu_out_t;

  function automatic alu_out_t model_alu(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    alu_out_t o;
    logic [63:0] ext;
    int sh;
    sh = int'(b % 32);
    o.res = 32'd0;
    o.e   = 1'b0;
    case (op)
      4'd0:  o.res = a + b;
      4'd1:  o.res = a + (~b + 32'd1);
      4'd2:  o.res = a & b;
      4'd3:  o.res = a | b;
      4'd4:  o.res = a ^ b;
      4'd5:  o.res = a * (32'd1 << sh);
      4'd6:  o.res = a / (32'd1 << sh);
      4'd7:  begin ext = {{32{a[31]}}, a} >> sh; o.res = ext[31:0]; end
      4'd8:  o.res = (a < b) ? 32'd1 : 32'd0;
      4'd9:  o.res = ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
      4'd10: o.res = b;
      default: begin o.res = 32'd0; o.e = 1'b1; end
    endcase
    o.z = (o.res == 32'd0);
    return o;
  endfunction

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    logic        e;
  } vec_t;

  vec_t vecs[15];

  // Random-phase model state
  logic        m_valid;
  alu_out_t    m_out;
  logic        m_id;
  logic [3:0]  m_tag;
  logic        last_served;
  logic [1:0]  pend;
  logic [3:0]  p_op[2];
  logic [31:0] p_a[2], p_b[2];
  logic [3:0]  p_tag[2];

  initial begin
    vecs[0]  = '{4'h0, 32'd5,          32'd7,          32'd12,         1'b0, 1'b0};
    vecs[1]  = '{4'h1, 32'd9,          32'd9,          32'd0,          1'b1, 1'b0};
    vecs[2]  = '{4'h1, 32'd3,          32'd5,          32'hFFFF_FFFE,  1'b0, 1'b0};
    vecs[3]  = '{4'h2, 32'hF0F0_F0F0,  32'hFF00_FF00,  32'hF000_F000,  1'b0, 1'b0};
    vecs[4]  = '{4'h3, 32'h0000_000F,  32'h0000_00F0,  32'h0000_00FF,  1'b0, 1'b0};
    vecs[5]  = '{4'h4, 32'hFFFF_0000,  32'hFF00_FF00,  32'h00FF_FF00,  1'b0, 1'b0};
    vecs[6]  = '{4'h5, 32'd1,          32'd31,         32'h8000_0000,  1'b0, 1'b0};
    vecs[7]  = '{4'h5, 32'd1,          32'd33,         32'h0000_0002,  1'b0, 1'b0};
    vecs[8]  = '{4'h6, 32'h8000_0000,  32'd4,          32'h0800_0000,  1'b0, 1'b0};
    vecs[9]  = '{4'h7, 32'h8000_0000,  32'd4,          32'hF800_0000,  1'b0, 1'b0};
    vecs[10] = '{4'h8, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1, 1'b0};
    vecs[11] = '{4'h9, 32'hFFFF_FFFF,  32'd1,          32'd1,          1'b0, 1'b0};
    vecs[12] = '{4'hA, 32'd7,          32'h1234_5000,  32'h1234_5000,  1'b0, 1'b0};
    vecs[13] = '{4'hF, 32'd3,          32'd4,          32'd0,          1'b1, 1'b1};
    vecs[14] = '{4'hB, 32'd1,          32'd1,          32'd0,          1'b1, 1'b1};

    // Reset held with both ports requesting
    rst_n     = 1'b0;
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    req_a = '0; req_b = '0; req_ctrl = '0; req_tag = '0;
    repeat (2) @(negedge clk);
    check("rst_req_ready", req_ready, 2'b00);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_result", rsp_result, 0);
    check("rst_rsp_flags", {rsp_zero, rsp_err, rsp_id}, 0);
    check("rst_rsp_tag", rsp_tag, 0);
    rst_n = 1'b1;
    #1;
    check("first_grant", req_ready, 2'b01);
    req_valid = 2'b00;

    // Directed vector table, alternating the issuing port
    for (int i = 0; i < 15; i++) begin
      int p;
      logic [3:0] tg;
      p  = i % 2;
      tg = 4'(i + 3);
      @(negedge clk);
      set_port(p, vecs[i].op, vecs[i].a, vecs[i].b, tg);
      req_valid = 2'(1 << p);
      #1;
      check($sformatf("vec%0d_ready", i), req_ready, 64'(1 << p));
      @(negedge clk);
      req_valid = 2'b00;
      check($sformatf("vec%0d_valid", i), rsp_valid, 1);
      check($sformatf("vec%0d_result", i), rsp_result, vecs[i].res);
      check($sformatf("vec%0d_zero", i), rsp_zero, vecs[i].z);
      check($sformatf("vec%0d_err", i), rsp_err, vecs[i].e);
      check($sformatf("vec%0d_id", i), rsp_id, p);
      check($sformatf("vec%0d_tag", i), rsp_tag, tg);
    end

    // Both ports saturated from a fresh reset: ids must alternate 0,1,0,1
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    set_port(0, 4'h0, 32'd1, 32'd1, 4'd1);
    set_port(1, 4'h1, 32'd9, 32'd9, 4'd2);
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("alt%0d_valid", k), rsp_valid, 1);
      check($sformatf("alt%0d_id", k), rsp_id, k % 2);
      check($sformatf("alt%0d_result", k), rsp_result, (k % 2) ? 0 : 2);
      check($sformatf("alt%0d_zero", k), rsp_zero, k % 2);
      check($sformatf("alt%0d_tag", k), rsp_tag, (k % 2) ? 2 : 1);
    end

    // Backpressure: slot holds port 1's SUB response while a new request waits
    req_valid = 2'b01;
    set_port(0, 4'h4, 32'h0000_00F0, 32'h0000_000F, 4'd5);
    rsp_ready = 1'b0;
    #1;
    check("bp_ready_0", req_ready, 2'b00);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("bp%0d_ready", k), req_ready, 2'b00);
      check($sformatf("bp%0d_valid", k), rsp_valid, 1);
      check($sformatf("bp%0d_result", k), rsp_result, 0);
      check($sformatf("bp%0d_flags", k), {rsp_zero, rsp_err, rsp_id}, 3'b101);
      check($sformatf("bp%0d_tag", k), rsp_tag, 2);
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_release_ready", req_ready, 2'b01);
    @(negedge clk);
    req_valid = 2'b00;
    rsp_ready = 1'b0;
    check("bp_new_valid", rsp_valid, 1);
    check("bp_new_result", rsp_result, 32'h0000_00FF);
    check("bp_new_id", rsp_id, 0);
    check("bp_new_tag", rsp_tag, 5);

    // Async reset while a response is held: must clear without a clock edge
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", rsp_valid, 0);
    check("async_rst_result", rsp_result, 0);
    check("async_rst_tag", rsp_tag, 0);
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;

    // Randomized run against the transaction-level model
    m_valid     = 1'b0;
    m_out       = '0;
    m_id        = 1'b0;
    m_tag       = '0;
    last_served = 1'b1;   // nobody served yet: port 0 wins the first tie
    pend        = 2'b00;
    for (int p = 0; p < 2; p++) begin
      p_op[p] = '0; p_a[p] = '0; p_b[p] = '0; p_tag[p] = '0;
    end
    for (int cyc = 0; cyc < 400; cyc++) begin
      int served;
      logic free;
      @(negedge clk);
      check("rnd_valid", rsp_valid, m_valid);
      if (m_valid) begin
        check("rnd_result", rsp_result, m_out.res);
        check("rnd_zero_err", {rsp_zero, rsp_err}, {m_out.z, m_out.e});
        check("rnd_id_tag", {rsp_id, rsp_tag}, {m_id, m_tag});
      end
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && $urandom_range(0, 2) != 0) begin
          pend[p]  = 1'b1;
          p_op[p]  = 4'($urandom_range(0, 15));
          p_a[p]   = $urandom;
          p_b[p]   = ($urandom_range(0, 3) == 0) ? p_a[p] : $urandom;
          p_tag[p] = 4'($urandom);
        end
        set_port(p, p_op[p], p_a[p], p_b[p], p_tag[p]);
      end
      req_valid = pend;
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      free   = !m_valid || rsp_ready;
      served = -1;
      if (free) begin
        if (pend == 2'b11) served = last_served ? 0 : 1;
        else if (pend[0])  served = 0;
        else if (pend[1])  served = 1;
      end
      check("rnd_ready", req_ready, (served >= 0) ? 64'(1 << served) : 64'd0);
      if (served >= 0) begin
        m_out       = model_alu(p_op[served], p_a[served], p_b[served]);
        m_valid     = 1'b1;
        m_id        = served[0];
        m_tag       = p_tag[served];
        last_served = served[0];
        pend[served] = 1'b0;
      end else if (rsp_ready) begin
        m_valid = 1'b0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one combinational `alu` instance between two requesters, e.g. two issue slots or an integer pipe plus a debug/CSR path. Uses round-robin arbitration with valid/ready handshakes. Results are registered with one-cycle latency and carry the requester ID and a caller tag. The block sits between the issue stage and writeback; no requester instantiates its own ALU.

## Interface
- `XLEN`, 32, operand/result width (fixed at 32; the ALU shift amounts use bits [4:0])
- `TAG_W`, 4, width of the opaque per-request tag returned with the result
- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  reset; asynchronous, active-low
- `req_valid`  in  2  request valid, bit i = port i
- `req_ready`  out  2  request accepted this cycle, bit i = port i
- `req_a`  in  2*XLEN  operand A, port i at [XLEN*i +: XLEN]
- `req_b`  in  2*XLEN  operand B, same packing
- `req_ctrl`  in  8  ALU op code, port i at [4*i +: 4]
- `req_tag`  in  2*TAG_W  caller tag, same packing
- `rsp_valid`  out  1  response valid
- `rsp_ready`  in  1  downstream accepts response
- `rsp_result`  out  XLEN  ALU result
- `rsp_zero`  out  1  result == 0
- `rsp_err`  out  1  op code was outside 0000..1010
- `rsp_id`  out  1  port that issued the request
- `rsp_tag`  out  TAG_W  tag of that request

## Operation
- Ops: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLTU, 9 SLT, A pass-B (LUI). Codes B..F are illegal: result 0, zero 1, err 1.
- Output slot state: EMPTY (`rsp_valid`=0) or FULL (`rsp_valid`=1).
- `slot_free = !rsp_valid | rsp_ready`.
- Arbitration uses a 1-bit `prio` pointer:
  - Both ports valid: grant port `prio`.
  - One port valid: grant that port.
  - No port valid: no grant.
- `req_ready[i] = grant[i] & slot_free & rst_n`. At most one bit is set per cycle. Ready may depend on valid; valid must never depend on ready.
- On accept (`req_valid[i] & req_ready[i]`):
  - The selected operands drive the ALU.
  - result, zero, err, id=i and tag are registered.
  - `rsp_valid` is set; `prio` becomes !i.
- Drain without a new accept (`rsp_valid & rsp_ready` and no grant): `rsp_valid` clears.
- Simultaneous drain and accept: the slot reloads with the new request; `rsp_valid` stays 1.
- Requester rule: a valid request holds valid and a stable payload until ready.
- Block rule: while `rsp_valid & !rsp_ready`, every `rsp_*` output holds stable.
- An unaccepted requester does not lose priority: `prio` changes only on an accept.

## Timing
- Reset (async assert, sync deassert by the system): `rsp_valid`=0, `rsp_result`=0, `rsp_zero`=0, `rsp_err`=0, `rsp_id`=0, `rsp_tag`=0, `prio`=0. `req_ready`=0 while `rst_n` is low.
- Reset mid-transfer discards the held response; no replay.
- Latency: accept at edge N gives `rsp_valid` from N+1.
- Throughput: 1 op/cycle with `rsp_ready` held high.
- With both ports saturated, grants strictly alternate; worst-case wait is 1 accept slot per port.
- Critical path: operand mux, then ALU (including 32-bit compare/shift), then result register. `req_ready` is purely combinational from `req_valid`, `prio`, `rsp_valid` and `rsp_ready`.

## Structure
- Shared package `alu_pkg` holds:
  - `XLEN`.
  - The 4-bit op-code constants (`ALU_ADD` … `ALU_LUI`).
  - An `ALU_OP_MAX` constant used for the illegal-op check.
- The existing `alu` is consumed from `alu_pkg` constants.
- One sub-module: the existing `alu`, instantiated once. The arbiter (`prio`, grant logic) stays inline, with no separate arbiter module.

## Test plan
- Reset held low with `req_valid`=2'b11 → `req_ready`=0, `rsp_valid`=0. After release, first grant goes to port 0.
- Port 0 only: ADD a=5, b=7, tag=3 → next cycle `rsp_valid`=1, result=12, zero=0, id=0, tag=3, err=0.
- Both ports valid for 4 cycles with `rsp_ready`=1:
  - Port 1 issues SUB 9,9; port 0 issues ADD 1,1.
  - Required: `rsp_id` sequence 0,1,0,1; port 1 responses give result=0, zero=1.
- Backpressure:
  - Hold `rsp_ready`=0 for 3 cycles with a pending request → `req_ready`=0 and all `rsp_*` outputs stable.
  - Raise `rsp_ready` → the pending request is accepted in that same cycle and the new response appears the next cycle.
- Shift/compare ops:
  - SRA a=0x8000_0000, b=4 → 0xF800_0000.
  - SRL with same operands → 0x0800_0000.
  - SLTU a=0xFFFF_FFFF, b=1 → 0; SLT with same operands → 1.
- Illegal op 4'hF with a=3, b=4 → result=0, zero=1, err=1.
- Async reset asserted while `rsp_valid`=1 → `rsp_valid` drops immediately without waiting for a clock edge.
